// File: rtl/tm_pkg.sv
// Shared constants and types for the digit template matcher.
package tm_pkg;

   localparam int NDIGIT        = 10;
   localparam int DEF_NPIX      = 2500;
   localparam int DEF_AW        = 12;
   localparam int DEF_SW        = 12;
   localparam int DEF_MIN_SCORE = 1875;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_SELECT = 3'd3,
      ST_DONE   = 3'd4
   } tm_state_e;

   typedef logic [DEF_SW-1:0] score_t;

endpackage

// File: rtl/tm_score_acc.sv
// Ten parallel agreement counters: each adds 1 when its template bit equals the image bit.
module tm_score_acc #(
   parameter int NDIGIT = 10,
   parameter int SW     = 12
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       clear_i,
   input  logic                       valid_i,
   input  logic [NDIGIT-1:0]          rom_bit_i,
   input  logic                       img_bit_i,
   output logic [NDIGIT-1:0][SW-1:0]  score_o
);

   logic [NDIGIT-1:0][SW-1:0] score_q;
   logic [NDIGIT-1:0][SW-1:0] score_d;

   // Clear wins over valid so a new pass always starts from zero.
   always_comb begin
      score_d = score_q;
      if (clear_i) begin
         score_d = '0;
      end else if (valid_i) begin
         for (int k = 0; k < NDIGIT; k++) begin
            score_d[k] = score_q[k] + {{(SW-1){1'b0}}, ~(rom_bit_i[k] ^ img_bit_i)};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score_o = score_q;

endmodule

// File: rtl/template_match_ctrl.sv
// Scans ten digit templates against the captured image and reports the best match.
// Optional macro TM_SCORE_OUT_EN adds the registered scores_all output.
module template_match_ctrl #(
   parameter int NPIX      = tm_pkg::DEF_NPIX,
   parameter int AW        = tm_pkg::DEF_AW,
   parameter int SW        = tm_pkg::DEF_SW,
   parameter int MIN_SCORE = tm_pkg::DEF_MIN_SCORE
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [3:0]                  digit,
   output logic [SW-1:0]               score,
   output logic                        result_valid,
   output logic                        rom_ce,
   output logic                        rom_oce,
   output logic [AW-1:0]               rom_ad,
   input  logic [tm_pkg::NDIGIT-1:0]   rom_dout,
   input  logic                        img_dout,
`ifdef TM_SCORE_OUT_EN
   output logic [tm_pkg::NDIGIT*SW-1:0] scores_all,
`endif
   output tm_pkg::tm_state_e           dbg_state
);

   import tm_pkg::*;

   localparam logic [AW-1:0] LAST_AD = AW'(NPIX - 1);
   localparam logic [SW-1:0] MIN_W   = SW'(MIN_SCORE);
   localparam logic [3:0]    LAST_IX = 4'(NDIGIT - 1);

   tm_state_e                 state_q;
   logic [AW-1:0]             rom_ad_q;
   logic                      rom_ce_q;
   logic                      valid_q;
   logic                      busy_q;
   logic                      done_q;
   logic [3:0]                digit_q;
   logic [SW-1:0]             score_q;
   logic                      result_valid_q;
   logic [3:0]                sel_idx_q;
   logic [3:0]                best_digit_q;
   logic [3:0]                best_digit_d;
   logic [SW-1:0]             best_score_q;
   logic [SW-1:0]             best_score_d;
   logic [SW-1:0]             sel_score;
   logic                      acc_clear;
   logic [NDIGIT-1:0][SW-1:0] acc_score;
`ifdef TM_SCORE_OUT_EN
   logic [NDIGIT*SW-1:0]      scores_all_q;
`endif

   assign acc_clear = (state_q == ST_IDLE) && start;

   tm_score_acc #(
      .NDIGIT (NDIGIT),
      .SW     (SW)
   ) u_acc (
      .clk_i     (clk),
      .reset_i   (reset),
      .clear_i   (acc_clear),
      .valid_i   (valid_q),
      .rom_bit_i (rom_dout),
      .img_bit_i (img_dout),
      .score_o   (acc_score)
   );

   // Argmax step: strict greater-than keeps the lower digit on a tie.
   always_comb begin
      sel_score = '0;
      for (int k = 0; k < NDIGIT; k++) begin
         if (sel_idx_q == 4'(k)) sel_score = acc_score[k];
      end
      best_digit_d = best_digit_q;
      best_score_d = best_score_q;
      if ((sel_idx_q == 4'd0) || (sel_score > best_score_q)) begin
         best_digit_d = sel_idx_q;
         best_score_d = sel_score;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rom_ad_q       <= '0;
         rom_ce_q       <= 1'b0;
         valid_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         digit_q        <= '0;
         score_q        <= '0;
         result_valid_q <= 1'b0;
         sel_idx_q      <= '0;
         best_digit_q   <= '0;
         best_score_q   <= '0;
`ifdef TM_SCORE_OUT_EN
         scores_all_q   <= '0;
`endif
      end else begin
         // ROM output is registered, so data trails the enable by one cycle.
         valid_q <= rom_ce_q;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_SCAN;
                  rom_ad_q <= '0;
                  rom_ce_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (rom_ad_q == LAST_AD) begin
                  state_q  <= ST_DRAIN;
                  rom_ce_q <= 1'b0;
                  rom_ad_q <= '0;
               end else begin
                  rom_ad_q <= rom_ad_q + 1'b1;
               end
            end
            ST_DRAIN: begin
               state_q   <= ST_SELECT;
               sel_idx_q <= '0;
            end
            ST_SELECT: begin
               best_digit_q <= best_digit_d;
               best_score_q <= best_score_d;
               if (sel_idx_q == LAST_IX) begin
                  state_q        <= ST_DONE;
                  done_q         <= 1'b1;
                  digit_q        <= best_digit_d;
                  score_q        <= best_score_d;
                  result_valid_q <= (best_score_d >= MIN_W);
`ifdef TM_SCORE_OUT_EN
                  scores_all_q   <= acc_score;
`endif
               end else begin
                  sel_idx_q <= sel_idx_q + 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign digit        = digit_q;
   assign score        = score_q;
   assign result_valid = result_valid_q;
   assign rom_ce       = rom_ce_q;
   assign rom_oce      = 1'b1;
   assign rom_ad       = rom_ad_q;
   assign dbg_state    = state_q;
`ifdef TM_SCORE_OUT_EN
   assign scores_all   = scores_all_q;
`endif

endmodule

// File: tb/tb_template_match_ctrl.sv
// Bench for template_match_ctrl: ROM/image model, pixel-counting reference, scenario tasks.
module tb_template_match_ctrl;

   localparam int NPIX = 2500;
   localparam int SW   = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              busy;
   logic              done;
   logic [3:0]        digit;
   logic [SW-1:0]     score;
   logic              result_valid;
   logic              rom_ce;
   logic              rom_oce;
   logic [11:0]       rom_ad;
   logic [9:0]        rom_dout = '0;
   logic              img_dout = 1'b0;
   tm_pkg::tm_state_e dbg_state;
`ifdef TM_SCORE_OUT_EN
   logic [10*SW-1:0]  scores_all;
`endif

   bit tmpl [10][NPIX];
   bit img  [NPIX];
   int plan_cnt [10];
   int exp_sc [10];
   int exp_digit;
   int exp_score;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   template_match_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .digit        (digit),
      .score        (score),
      .result_valid (result_valid),
      .rom_ce       (rom_ce),
      .rom_oce      (rom_oce),
      .rom_ad       (rom_ad),
      .rom_dout     (rom_dout),
      .img_dout     (img_dout),
`ifdef TM_SCORE_OUT_EN
      .scores_all   (scores_all),
`endif
      .dbg_state    (dbg_state)
   );

   // Registered-output pROM and capture buffer.
   always @(posedge clk) begin
      if (rom_ce) begin
         for (int k = 0; k < 10; k++) rom_dout[k] <= tmpl[k][rom_ad];
         img_dout <= img[rom_ad];
      end
   end

   // Reference: count agreeing pixels directly, then first-highest wins.
   task automatic model_compute();
      for (int k = 0; k < 10; k++) begin
         exp_sc[k] = 0;
         for (int i = 0; i < NPIX; i++) if (tmpl[k][i] == img[i]) exp_sc[k]++;
      end
      exp_digit = 0;
      exp_score = exp_sc[0];
      for (int k = 1; k < 10; k++) begin
         if (exp_sc[k] > exp_score) begin
            exp_digit = k;
            exp_score = exp_sc[k];
         end
      end
   endtask

   task automatic build_random(input int copy_k);
      for (int i = 0; i < NPIX; i++) begin
         img[i] = 1'($urandom_range(0, 1));
         for (int k = 0; k < 10; k++) tmpl[k][i] = 1'($urandom_range(0, 1));
         if (copy_k >= 0) img[i] = tmpl[copy_k][i];
      end
   endtask

   // Template k agrees with the image on exactly plan_cnt[k] pixels at a random rotation.
   task automatic build_counts();
      int off;
      for (int i = 0; i < NPIX; i++) img[i] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 10; k++) begin
         off = $urandom_range(0, NPIX - 1);
         for (int i = 0; i < NPIX; i++)
            tmpl[k][i] = (((i + off) % NPIX) < plan_cnt[k]) ? img[i] : ~img[i];
      end
   endtask

   // One pass from a start pulse; n counts falling edges after the accepting edge.
   task automatic run_pass(input int mid_start_at, output int latency, output int ce_cnt,
                           output int ad_err, output int done_cnt, output int busy_err);
      int n;
      int exp_ad;
      latency = -1; ce_cnt = 0; ad_err = 0; done_cnt = 0; busy_err = 0;
      exp_ad = 0;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (n < 3000 && !(latency >= 0 && n >= latency + 2)) begin
         @(negedge clk);
         n++;
         start = (n == mid_start_at);
         if (rom_ce) begin
            if (rom_ad !== 12'(exp_ad)) ad_err++;
            exp_ad++;
            ce_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (latency < 0) latency = n;
         end
         if (!busy && latency < 0) busy_err++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
      checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", digit); end
      checks++; if (score !== 12'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0b want 0", result_valid); end
      checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %0b want 0", rom_ce); end
      checks++; if (rom_ad !== 12'd0) begin errors++; $display("FAIL reset_ad: got %0d want 0", rom_ad); end
      checks++; if (rom_oce !== 1'b1) begin errors++; $display("FAIL reset_oce: got %0b want 1", rom_oce); end
      checks++; if (dbg_state !== tm_pkg::ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_match_template7();
      int lat, ce, ade, dc, be;
      build_random(7);
      model_compute();
      run_pass(-1, lat, ce, ade, dc, be);
      checks++; if (lat !== NPIX + 12) begin errors++; $display("FAIL t7_latency: got %0d want %0d", lat, NPIX + 12); end
      checks++; if (digit !== 4'(exp_digit) || exp_digit != 7) begin errors++; $display("FAIL t7_digit: got %0d want %0d", digit, exp_digit); end
      checks++; if (score !== 12'(NPIX)) begin errors++; $display("FAIL t7_score: got %0d want %0d", score, NPIX); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL t7_rv: got %0b want 1", result_valid); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL t7_done_count: got %0d want 1", dc); end
      checks++; if (busy !== 1'b0 || be !== 0) begin errors++; $display("FAIL t7_busy: got busy=%0b gaps=%0d want 0/0", busy, be); end
   endtask

   task automatic test_tie_lower_digit();
      int lat, ce, ade, dc, be;
      for (int k = 0; k < 10; k++) plan_cnt[k] = $urandom_range(0, 1500);
      plan_cnt[3] = 2100;
      plan_cnt[5] = 2100;
      build_counts();
      model_compute();
      run_pass(-1, lat, ce, ade, dc, be);
      checks++; if (digit !== 4'd3 || exp_digit != 3) begin errors++; $display("FAIL tie_digit: got %0d want 3 (model %0d)", digit, exp_digit); end
      checks++; if (score !== 12'd2100 || exp_score != 2100) begin errors++; $display("FAIL tie_score: got %0d want 2100 (model %0d)", score, exp_score); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL tie_rv: got %0b want 1", result_valid); end
   endtask

   task automatic test_below_threshold();
      int lat, ce, ade, dc, be;
      for (int k = 0; k < 9; k++) plan_cnt[k] = $urandom_range(0, 1799);
      plan_cnt[9] = 1800;
      build_counts();
      model_compute();
      run_pass(-1, lat, ce, ade, dc, be);
      checks++; if (digit !== 4'(exp_digit) || exp_digit != 9) begin errors++; $display("FAIL low_digit: got %0d want %0d", digit, exp_digit); end
      checks++; if (score !== 12'(exp_score) || exp_score != 1800) begin errors++; $display("FAIL low_score: got %0d want %0d", score, exp_score); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL low_rv: got %0b want 0", result_valid); end
   endtask

   task automatic test_addr_seq_ignore_start();
      int lat, ce, ade, dc, be;
      build_random(-1);
      model_compute();
      run_pass($urandom_range(10, 2400), lat, ce, ade, dc, be);
      checks++; if (ce !== NPIX) begin errors++; $display("FAIL seq_ce_cycles: got %0d want %0d", ce, NPIX); end
      checks++; if (ade !== 0) begin errors++; $display("FAIL seq_addr_gaps: got %0d want 0", ade); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL seq_done_count: got %0d want 1", dc); end
      checks++; if (lat !== NPIX + 12) begin errors++; $display("FAIL seq_latency: got %0d want %0d", lat, NPIX + 12); end
      checks++; if (digit !== 4'(exp_digit) || score !== 12'(exp_score)) begin errors++; $display("FAIL seq_result: got %0d/%0d want %0d/%0d", digit, score, exp_digit, exp_score); end
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || dbg_state !== tm_pkg::ST_IDLE) begin errors++; $display("FAIL seq_no_requeue: got busy=%0b state=%0d want 0/0", busy, dbg_state); end
   endtask

   task automatic test_start_held();
      int n, d1, d2, low;
      build_random(-1);
      model_compute();
      @(negedge clk);
      start = 1'b1;
      n = 0; d1 = -1; d2 = -1; low = 0;
      while (n < 6000 && d2 < 0) begin
         @(negedge clk);
         n++;
         if (done) begin
            if (d1 < 0) d1 = n; else d2 = n;
         end
         if (d1 >= 0 && n > d1 && d2 < 0 && !busy) low++;
      end
      start = 1'b0;
      checks++; if (d2 - d1 !== NPIX + 13 || d1 < 0) begin errors++; $display("FAIL held_restart_gap: got %0d want %0d", d2 - d1, NPIX + 13); end
      checks++; if (low !== 1) begin errors++; $display("FAIL held_idle_cycles: got %0d want 1", low); end
      checks++; if (digit !== 4'(exp_digit) || score !== 12'(exp_score)) begin errors++; $display("FAIL held_result: got %0d/%0d want %0d/%0d", digit, score, exp_digit, exp_score); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_stop: got busy=%0b want 0", busy); end
   endtask

   task automatic test_reset_mid_scan();
      int n, dc, lat, ce, ade, dn, be;
      build_random(-1);
      model_compute();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (rom_ad !== 12'd1200 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 3000) begin errors++; $display("FAIL abort_reach_1200: got timeout want rom_ad=1200"); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if ({busy, done, result_valid, rom_ce} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b want 0000", {busy, done, result_valid, rom_ce}); end
      checks++; if (digit !== 4'd0 || score !== 12'd0 || rom_ad !== 12'd0) begin errors++; $display("FAIL abort_values: got %0d/%0d/%0d want 0/0/0", digit, score, rom_ad); end
      dc = 0;
      repeat (1400) begin
         @(negedge clk);
         if (done) dc++;
      end
      checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dc); end
      run_pass(-1, lat, ce, ade, dn, be);
      checks++; if (dn !== 1 || lat !== NPIX + 12) begin errors++; $display("FAIL abort_rerun: got done=%0d lat=%0d want 1/%0d", dn, lat, NPIX + 12); end
      checks++; if (digit !== 4'(exp_digit) || score !== 12'(exp_score)) begin errors++; $display("FAIL abort_result: got %0d/%0d want %0d/%0d", digit, score, exp_digit, exp_score); end
   endtask

`ifdef TM_SCORE_OUT_EN
   task automatic test_scores_all();
      int lat, ce, ade, dc, be;
      for (int k = 0; k < 10; k++) plan_cnt[k] = 200 * k + $urandom_range(0, 150);
      build_counts();
      model_compute();
      run_pass(-1, lat, ce, ade, dc, be);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (scores_all[k*SW +: SW] !== 12'(exp_sc[k])) begin
            errors++;
            $display("FAIL scores_all_%0d: got %0d want %0d", k, scores_all[k*SW +: SW], exp_sc[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_match_template7();
      test_tie_lower_digit();
      test_below_threshold();
      test_addr_seq_ignore_start();
      test_start_held();
      test_reset_mid_scan();
`ifdef TM_SCORE_OUT_EN
      test_scores_all();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
